// File: rtl/snake_speed_ctrl_if.sv
// snake_speed_ctrl_if: game-control handshake between the snake game logic and the speed controller
interface snake_speed_ctrl_if;
  logic start_btn;
  logic pause_btn;
  logic collision;
  logic food_eaten;
  logic tick;
  logic mov_enable;
  logic mov_rst;
  logic [27:0] mov_speed;
  logic step_req;
  logic [1:0] state;
  logic [7:0] score;
  logic [3:0] level;
  modport master (
    output start_btn, pause_btn, collision, food_eaten, tick,
    input mov_enable, mov_rst, mov_speed, step_req, state, score, level
  );
  modport slave (
    input start_btn, pause_btn, collision, food_eaten, tick,
    output mov_enable, mov_rst, mov_speed, step_req, state, score, level
  );
endinterface

// File: rtl/snake_speed_ctrl.sv
// snake_speed_ctrl: game FSM tracking score/level and shortening the move-tick period on each level-up
module snake_speed_ctrl #(
  parameter logic [27:0] BASE_SPEED = 28'd25_000_000,
  parameter logic [27:0] SPEED_STEP = 28'd2_000_000,
  parameter logic [27:0] MIN_SPEED = 28'd5_000_000,
  parameter int FOODS_PER_LEVEL = 4
) (
  input logic clk,
  input logic rst,
  snake_speed_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, PLAY, PAUSE, OVER} state_e;
  state_e state_q;
  logic [7:0] score_q;
  logic [3:0] level_q;
  logic [3:0] cnt_q;
  logic [27:0] speed_q;
  logic mov_rst_q;
  logic step_q;
  logic eat;
  logic lvl_up;
  logic [28:0] floor_sum;
  logic [27:0] speed_dn;
  assign eat = state_q == PLAY && bus.food_eaten && !bus.collision;
  assign lvl_up = eat && cnt_q == 4'(FOODS_PER_LEVEL - 1);
  // 29-bit sum keeps the floor comparison free of wrap-around for large parameters
  assign floor_sum = {1'b0, MIN_SPEED} + {1'b0, SPEED_STEP};
  assign speed_dn = {1'b0, speed_q} >= floor_sum ? speed_q - SPEED_STEP : MIN_SPEED;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      score_q <= 8'd0;
      level_q <= 4'd0;
      cnt_q <= 4'd0;
      speed_q <= BASE_SPEED;
      mov_rst_q <= 1'b0;
      step_q <= 1'b0;
    end else begin
      mov_rst_q <= state_q == IDLE && bus.start_btn;
      step_q <= state_q == PLAY && bus.tick && !bus.collision;
      if (eat) begin
        score_q <= score_q == 8'hff ? score_q : score_q + 8'd1;
        cnt_q <= lvl_up ? 4'd0 : cnt_q + 4'd1;
      end
      if (lvl_up) begin
        level_q <= level_q == 4'hf ? level_q : level_q + 4'd1;
        speed_q <= speed_dn;
      end
      unique case (state_q)
        IDLE: if (bus.start_btn) begin
          state_q <= PLAY;
          score_q <= 8'd0;
          level_q <= 4'd0;
          cnt_q <= 4'd0;
          speed_q <= BASE_SPEED;
        end
        PLAY: state_q <= bus.collision ? OVER : bus.pause_btn ? PAUSE : PLAY;
        PAUSE: state_q <= bus.pause_btn ? PLAY : PAUSE;
        OVER: state_q <= bus.start_btn ? IDLE : OVER;
      endcase
    end
  end
  assign bus.mov_enable = state_q == PLAY;
  assign bus.mov_rst = mov_rst_q;
  assign bus.mov_speed = speed_q;
  assign bus.step_req = step_q;
  assign bus.state = state_q;
  assign bus.score = score_q;
  assign bus.level = level_q;
endmodule

// File: tb/tb_snake_speed_ctrl.sv
// tb_snake_speed_ctrl: scoreboard bench comparing the controller against a cycle model of the game rules
module tb_snake_speed_ctrl;
  localparam int BASE = 25_000_000;
  localparam int STEP = 2_000_000;
  localparam int MINS = 5_000_000;
  localparam int FPL = 4;
  localparam logic [44:0] RST_VEC = {2'd0, 8'd0, 4'd0, 28'd25_000_000, 3'b000};
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  int m_state, m_score, m_level, m_cnt, m_speed;
  logic m_rst, m_step;
  logic [44:0] exp_q[$];
  logic [44:0] obs_q[$];
  snake_speed_ctrl_if bus ();
  snake_speed_ctrl #(
    .BASE_SPEED(28'd25_000_000),
    .SPEED_STEP(28'd2_000_000),
    .MIN_SPEED(28'd5_000_000),
    .FOODS_PER_LEVEL(FPL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus.slave)
  );
  always #5 clk = ~clk;
  function automatic logic [44:0] model_vec();
    return {2'(m_state), 8'(m_score), 4'(m_level), 28'(m_speed), m_rst, m_step, m_state == 1};
  endfunction
  function automatic logic [44:0] dut_vec();
    return {bus.state, bus.score, bus.level, bus.mov_speed, bus.mov_rst, bus.step_req, bus.mov_enable};
  endfunction
  task automatic model_reset();
    m_state = 0; m_score = 0; m_level = 0; m_cnt = 0; m_speed = BASE; m_rst = 0; m_step = 0;
  endtask
  task automatic drive(input logic s, input logic p, input logic c, input logic f, input logic t);
    bus.start_btn = s; bus.pause_btn = p; bus.collision = c; bus.food_eaten = f; bus.tick = t;
    @(posedge clk);
    m_step = m_state == 1 && t && !c;
    m_rst = m_state == 0 && s;
    case (m_state)
      0: if (s) begin
        m_state = 1; m_score = 0; m_level = 0; m_cnt = 0; m_speed = BASE;
      end
      1: if (c) m_state = 3;
      else begin
        if (p) m_state = 2;
        if (f) begin
          if (m_score != 255) m_score++;
          if (m_cnt == FPL - 1) begin
            m_cnt = 0;
            if (m_level != 15) m_level++;
            m_speed = m_speed >= MINS + STEP ? m_speed - STEP : MINS;
          end else m_cnt++;
        end
      end
      2: if (p) m_state = 1;
      default: if (s) m_state = 0;
    endcase
    exp_q.push_back(model_vec());
    @(negedge clk);
    obs_q.push_back(dut_vec());
    bus.start_btn = 0; bus.pause_btn = 0; bus.collision = 0; bus.food_eaten = 0; bus.tick = 0;
  endtask
  task automatic test_reset();
    logic [44:0] e, o;
    checks++;
    if (dut_vec() !== RST_VEC) begin
      errors++; $display("FAIL reset_hold: got %h expected %h", dut_vec(), RST_VEC);
    end
    @(negedge clk);
    rst = 0;
    model_reset();
    repeat (2) drive(0, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_release: got %h expected %h", o, e); end
    end
  endtask
  task automatic test_start();
    logic [44:0] e, o;
    drive(1, 0, 0, 0, 0);
    checks++;
    if (bus.state !== 2'd1 || bus.mov_rst !== 1'b1 || bus.mov_speed !== 28'd25_000_000 || bus.mov_enable !== 1'b1) begin
      errors++; $display("FAIL start: got st=%0d rst=%b spd=%0d en=%b expected st=1 rst=1 spd=25000000 en=1", bus.state, bus.mov_rst, bus.mov_speed, bus.mov_enable);
    end
    drive(0, 0, 0, 0, 0);
    checks++;
    if (bus.mov_rst !== 1'b0) begin errors++; $display("FAIL start_rst_pulse: got %b expected 0", bus.mov_rst); end
    drive(1, 0, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL start_sb: got %h expected %h", o, e); end
    end
  endtask
  task automatic test_food();
    logic [44:0] e, o;
    repeat (4) drive(0, 0, 0, 1, 0);
    checks++;
    if (bus.score !== 8'd4 || bus.level !== 4'd1 || bus.mov_speed !== 28'd23_000_000) begin
      errors++; $display("FAIL food_lvl1: got sc=%0d lv=%0d spd=%0d expected 4 1 23000000", bus.score, bus.level, bus.mov_speed);
    end
    repeat (36) drive(0, 0, 0, 1, 0);
    checks++;
    if (bus.level !== 4'd10 || bus.mov_speed !== 28'd5_000_000) begin
      errors++; $display("FAIL food_lvl10: got lv=%0d spd=%0d expected 10 5000000", bus.level, bus.mov_speed);
    end
    repeat (8) drive(0, 0, 0, 1, 0);
    checks++;
    if (bus.level !== 4'd12 || bus.mov_speed !== 28'd5_000_000) begin
      errors++; $display("FAIL food_floor: got lv=%0d spd=%0d expected 12 5000000", bus.level, bus.mov_speed);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL food_sb: got %h expected %h", o, e); end
    end
  endtask
  task automatic test_pause();
    logic [44:0] e, o;
    logic [5:0] st;
    logic mr;
    drive(0, 0, 0, 0, 1); st[0] = bus.step_req;
    drive(0, 0, 0, 0, 0); st[1] = bus.step_req;
    drive(0, 1, 0, 0, 0); st[2] = bus.step_req;
    drive(0, 0, 0, 0, 1); st[3] = bus.step_req;
    drive(0, 1, 0, 0, 0); st[4] = bus.step_req; mr = bus.mov_rst;
    drive(0, 0, 0, 0, 1); st[5] = bus.step_req;
    checks++;
    if (st !== 6'b100001 || mr !== 1'b0) begin
      errors++; $display("FAIL pause_steps: got %b rst=%b expected 100001 rst=0", st, mr);
    end
    drive(0, 1, 0, 1, 1);
    checks++;
    if (bus.state !== 2'd2 || bus.score !== 8'd49 || bus.step_req !== 1'b1) begin
      errors++; $display("FAIL pause_food_tick: got st=%0d sc=%0d step=%b expected 2 49 1", bus.state, bus.score, bus.step_req);
    end
    drive(1, 0, 1, 1, 1);
    drive(0, 1, 0, 0, 0);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL pause_sb: got %h expected %h", o, e); end
    end
  endtask
  task automatic test_collision();
    logic [44:0] e, o;
    drive(0, 1, 1, 1, 1);
    checks++;
    if (bus.state !== 2'd3 || bus.score !== 8'd49 || bus.step_req !== 1'b0) begin
      errors++; $display("FAIL collision: got st=%0d sc=%0d step=%b expected 3 49 0", bus.state, bus.score, bus.step_req);
    end
    drive(0, 1, 0, 1, 1);
    drive(1, 0, 0, 0, 0);
    checks++;
    if (bus.state !== 2'd0 || bus.score !== 8'd49 || bus.level !== 4'd12 || bus.mov_speed !== 28'd5_000_000) begin
      errors++; $display("FAIL over_hold: got st=%0d sc=%0d lv=%0d spd=%0d expected 0 49 12 5000000", bus.state, bus.score, bus.level, bus.mov_speed);
    end
    drive(0, 0, 0, 1, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL collision_sb: got %h expected %h", o, e); end
    end
  endtask
  task automatic test_saturate_reset();
    logic [44:0] e, o;
    drive(1, 0, 0, 0, 0);
    repeat (300) drive(0, 0, 0, 1, 0);
    drive(0, 0, 0, 0, 1);
    checks++;
    if (bus.score !== 8'd255 || bus.level !== 4'd15 || bus.mov_speed !== 28'd5_000_000) begin
      errors++; $display("FAIL saturate: got sc=%0d lv=%0d spd=%0d expected 255 15 5000000", bus.score, bus.level, bus.mov_speed);
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL saturate_sb: got %h expected %h", o, e); end
    end
    #2 rst = 1;
    #1;
    checks++;
    if (dut_vec() !== RST_VEC) begin
      errors++; $display("FAIL async_reset: got %h expected %h", dut_vec(), RST_VEC);
    end
    @(negedge clk);
    rst = 0;
    model_reset();
    repeat (2) drive(0, 0, 0, 1, 1);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front(); checks++;
      if (o !== e) begin errors++; $display("FAIL reset_release_sb: got %h expected %h", o, e); end
    end
  endtask
  initial begin
    bus.start_btn = 0; bus.pause_btn = 0; bus.collision = 0; bus.food_eaten = 0; bus.tick = 0;
    model_reset();
    repeat (2) @(negedge clk);
    test_reset();
    test_start();
    test_food();
    test_pause();
    test_collision();
    test_saturate_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
